jk_bank_sequencer: RTL

- Command-driven controller for an external bank of WIDTH J-K flip-flops, one per bit.
- Drives the per-bit J and K inputs and reads the bank's Q outputs back.
- The bank is operated as a loadable synchronous up/down counter.
- Accepts commands over a valid/ready handshake, sequences the bank for the requested number of clock edges, then signals completion.

---
 rtl/jk_bank_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/jk_bank_sequencer.sv
// Sequences an external bank of J-K flip-flops as a loadable up/down counter under command control.
// Accept-to-done: NOP 1 cycle, LOAD 2 cycles, UP/DOWN steps+1 cycles (1 cycle when steps==0).
// cmd_ready is high only in IDLE; a command offered while busy is not queued and must be held.
module jk_bank_sequencer #(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [WIDTH-1:0]  cmd_data,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [WIDTH-1:0]  q_in,
   output logic [WIDTH-1:0]  j,
   output logic [WIDTH-1:0]  k,
   output logic              busy,
   output logic              done,
   output logic              wrap
);

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_UP   = 2'b10;
   localparam logic [1:0] OP_DOWN = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_COUNT,
      S_DONE
   } state_t;

   // Command fields held for the whole operation.
   typedef struct packed {
      logic [1:0]       op;
      logic [WIDTH-1:0] data;
   } cmd_t;

   state_t            state;
   cmd_t              cmd_q;
   logic [STEP_W-1:0] remaining;
   logic              accept;
   logic              count_up;
   logic              count_down;
   logic              wrap_now;
   logic [WIDTH-1:0]  toggle;

   assign accept     = cmd_valid && (state == S_IDLE);
   assign count_up   = (cmd_q.op == OP_UP);
   assign count_down = (cmd_q.op == OP_DOWN);

   // The bank rolls over on this edge when every bit toggles: all ones going up, all zeros going down.
   assign wrap_now   = (count_up && (&q_in)) || (count_down && ~(|q_in));

   // Ripple enable chain: a bit toggles when every lower bit is at its carry (up) or borrow (down) value.
   always_comb begin
      toggle    = '0;
      toggle[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         toggle[i] = toggle[i-1] & (count_up ? q_in[i-1] : ~q_in[i-1]);
      end
   end

   // Bank drive: load pattern in LOAD, toggle chain in COUNT, hold (J=K=0) everywhere else.
   always_comb begin
      j = '0;
      k = '0;
      unique case (state)
         S_LOAD: begin
            j = cmd_q.data;
            k = ~cmd_q.data;
         end
         S_COUNT: begin
            j = toggle;
            k = toggle;
         end
         default: begin
            j = '0;
            k = '0;
         end
      endcase
   end

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   // Control FSM with registered done/wrap pulses; clr shares the bank's asynchronous clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= S_IDLE;
         cmd_q     <= '0;
         remaining <= '0;
         done      <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         done <= 1'b0;
         wrap <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  cmd_q.op   <= cmd_op;
                  cmd_q.data <= cmd_data;
                  remaining  <= cmd_steps;
                  unique case (cmd_op)
                     OP_NOP: begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end
                     OP_LOAD: begin
                        state <= S_LOAD;
                     end
                     default: begin
                        // Zero-length count completes immediately without touching the bank.
                        if (cmd_steps == '0) begin
                           state <= S_DONE;
                           done  <= 1'b1;
                        end else begin
                           state <= S_COUNT;
                        end
                     end
                  endcase
               end
            end
            S_LOAD: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_COUNT: begin
               // remaining is at least 1 here, so the decrement never underflows.
               remaining <= remaining - STEP_W'(1);
               wrap      <= wrap_now;
               if (remaining == STEP_W'(1)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
